// File: rtl/mus_pkg.sv
// Shared types and constants for the melody sequencer.
// Note codes: 0 = do .. E = hi re, all-ones = rest.
package mus_pkg;

    typedef logic [3:0] note_t;

    localparam note_t N_DO      = 4'h0;
    localparam note_t N_HI_RE   = 4'hE;
    localparam note_t NOTE_REST = 4'hF;

    localparam int MEL_LEN = 16;

    localparam note_t DEFAULT_MELODY [MEL_LEN] = '{
        4'h0, 4'hC, 4'h7, 4'h0, 4'h5, 4'h7, 4'h9, 4'hF,
        4'h4, 4'h2, 4'h0, 4'hC, 4'h7, 4'h5, 4'h4, 4'hF
    };

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DONE
    } seq_state_t;

    // s = min(intensity-1, idx_w); intensity 0 is muted elsewhere
    function automatic int unsigned gate_shift(
        input logic [3:0] inten,
        input int unsigned idx_w
    );
        int unsigned s;
        s = (inten == 4'd0) ? 0 : 32'(inten) - 1;
        return (s > idx_w) ? idx_w : s;
    endfunction

endpackage

// File: rtl/mus_sequencer_if.sv
// Note table write port between the game FSM and the sequencer.
interface mus_sequencer_if #(
    parameter int NOTE_W = 4,
    parameter int LEN    = 16
);
    localparam int IDX_W = $clog2(LEN);

    logic              wrEn;
    logic [IDX_W-1:0]  wrAddr;
    logic [NOTE_W-1:0] wrData;

    modport master (
        output wrEn,
        output wrAddr,
        output wrData
    );

    modport slave (
        input wrEn,
        input wrAddr,
        input wrData
    );
endinterface

// File: rtl/mus_note_table.sv
// LEN x NOTE_W note table: one write port, async read, write-first bypass.
// Contents survive reset; power-up image is the default melody.
module mus_note_table
    import mus_pkg::*;
#(
    parameter int NOTE_W = 4,
    parameter int LEN    = 16,
    localparam int IDX_W = $clog2(LEN)
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [IDX_W-1:0]  wrAddr,
    input  logic [NOTE_W-1:0] wrData,
    input  logic [IDX_W-1:0]  rdAddr,
    output logic [NOTE_W-1:0] rdData
);

    function automatic logic [LEN*NOTE_W-1:0] init_img();
        logic [LEN*NOTE_W-1:0] img;
        note_t e;
        img = '0;
        for (int i = 0; i < LEN; i++) begin
            e = DEFAULT_MELODY[i % MEL_LEN];
            img[i*NOTE_W +: NOTE_W] = (e == NOTE_REST) ? '1 : NOTE_W'(e);
        end
        return img;
    endfunction

    logic [LEN*NOTE_W-1:0] mem = init_img();

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr*NOTE_W +: NOTE_W] <= wrData;
        end
    end

    always_comb begin
        rdData = mem[rdAddr*NOTE_W +: NOTE_W];
        if (wrEn && (wrAddr == rdAddr)) begin
            rdData = wrData;
        end
    end

endmodule

// File: rtl/mus_sequencer.sv
// Melody sequencer: start/stop FSM, step counter, intensity gate, outputs.
// MUS_SEQ_TRANSPOSE_EN adds a transpose input sampled at start.
module mus_sequencer
    import mus_pkg::*;
#(
    parameter int NOTE_W = 4,
    parameter int LEN    = 16,
    localparam int IDX_W = $clog2(LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loopMode,
    input  logic              switchNote,
    input  logic [3:0]        intensity,
`ifdef MUS_SEQ_TRANSPOSE_EN
    input  logic [3:0]        transpose,
`endif
    mus_sequencer_if.slave    wr,
    output logic [NOTE_W-1:0] note,
    output logic              noteEnable,
    output logic [IDX_W-1:0]  stepIdx,
    output logic              playing,
    output logic              donePulse
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(LEN - 1);
    localparam logic [NOTE_W-1:0] REST = '1;

    seq_state_t        state, nxtState;
    logic [IDX_W-1:0]  nxtIdx, rdAddr, gateMask;
    logic [NOTE_W-1:0] nxtNote, rdData, playNote;
    logic              nxtEn, load, gateOk;

    mus_note_table #(
        .NOTE_W (NOTE_W),
        .LEN    (LEN)
    ) u_table (
        .clk    (clk),
        .wrEn   (wr.wrEn),
        .wrAddr (wr.wrAddr),
        .wrData (wr.wrData),
        .rdAddr (rdAddr),
        .rdData (rdData)
    );

`ifdef MUS_SEQ_TRANSPOSE_EN
    logic [3:0] trReg, trEff;

    function automatic logic [NOTE_W-1:0] xpose(
        input logic [NOTE_W-1:0] n,
        input logic [3:0]        t
    );
        int v;
        if (n == REST) return n;
        v = int'(n) + int'($signed(t));
        if (v < 0) v = 0;
        if (v > (2**NOTE_W) - 2) v = (2**NOTE_W) - 2;
        return NOTE_W'(v);
    endfunction

    assign trEff    = start ? transpose : trReg;
    assign playNote = xpose(rdData, trEff);

    always_ff @(posedge clk) begin
        if (reset) begin
            trReg <= '0;
        end else if (start && !stop) begin
            trReg <= transpose;
        end
    end
`else
    assign playNote = rdData;
`endif

    assign rdAddr   = start ? '0 : stepIdx + IDX_W'(1);
    assign gateMask = IDX_W'((32'd1 << gate_shift(intensity, IDX_W)) - 32'd1);
    assign gateOk   = (rdData != REST) && (intensity != 4'd0) &&
                      ((rdAddr & gateMask) == '0);

    assign playing   = (state == PLAY);
    assign donePulse = (state == DONE);

    always_comb begin
        nxtState = state;
        nxtIdx   = stepIdx;
        nxtNote  = note;
        nxtEn    = noteEnable;
        load     = 1'b0;
        if (stop) begin
            nxtState = IDLE;
            nxtEn    = 1'b0;
        end else if (start) begin
            nxtState = PLAY;
            load     = 1'b1;
        end else begin
            unique case (state)
                PLAY: begin
                    if (switchNote) begin
                        if (stepIdx == LAST && !loopMode) begin
                            nxtState = DONE;
                            nxtEn    = 1'b0;
                        end else begin
                            load = 1'b1;
                        end
                    end
                end
                DONE: begin
                    nxtState = IDLE;
                    nxtEn    = 1'b0;
                end
                default: begin
                    nxtEn = 1'b0;
                end
            endcase
        end
        if (load) begin
            nxtIdx  = rdAddr;
            nxtNote = playNote;
            nxtEn   = gateOk;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            stepIdx    <= '0;
            note       <= '0;
            noteEnable <= 1'b0;
        end else begin
            state      <= nxtState;
            stepIdx    <= nxtIdx;
            note       <= nxtNote;
            noteEnable <= nxtEn;
        end
    end

endmodule

// File: tb/tb_mus_sequencer.sv
// Directed bench for mus_sequencer: vector table plus hand-written
// sequences for table writes, reset mid-play and transpose.
module tb_mus_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loopMode = 1'b1;
    logic       switchNote = 1'b0;
    logic [3:0] intensity = 4'd1;
`ifdef MUS_SEQ_TRANSPOSE_EN
    logic [3:0] transpose = 4'd0;
`endif
    logic [3:0] note;
    logic       noteEnable;
    logic [3:0] stepIdx;
    logic       playing;
    logic       donePulse;

    int total = 0;
    int bad = 0;

    mus_sequencer_if #(.NOTE_W(4), .LEN(16)) wif ();

    mus_sequencer #(.NOTE_W(4), .LEN(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .loopMode   (loopMode),
        .switchNote (switchNote),
        .intensity  (intensity),
`ifdef MUS_SEQ_TRANSPOSE_EN
        .transpose  (transpose),
`endif
        .wr         (wif),
        .note       (note),
        .noteEnable (noteEnable),
        .stepIdx    (stepIdx),
        .playing    (playing),
        .donePulse  (donePulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, st, sp, sw, lm;
        logic [3:0] inten;
        logic [3:0] note;
        logic       en;
        logic [3:0] idx;
        logic       play, done;
    } vec_t;

    vec_t vq[$];

    logic [3:0] mel [16] = '{
        4'h0, 4'hC, 4'h7, 4'h0, 4'h5, 4'h7, 4'h9, 4'hF,
        4'h4, 4'h2, 4'h0, 4'hC, 4'h7, 4'h5, 4'h4, 4'hF
    };

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic void add(
        input logic r, st, sp, sw, lm,
        input logic [3:0] inten, n,
        input logic e,
        input logic [3:0] idx,
        input logic p, d
    );
        vq.push_back('{r, st, sp, sw, lm, inten, n, e, idx, p, d});
    endfunction

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            reset      = vq[i].rst;
            start      = vq[i].st;
            stop       = vq[i].sp;
            switchNote = vq[i].sw;
            loopMode   = vq[i].lm;
            intensity  = vq[i].inten;
            @(negedge clk);
            reset = 1'b0; start = 1'b0; stop = 1'b0; switchNote = 1'b0;
            chk($sformatf("%s%0d_note", tag, i), 8'(note), 8'(vq[i].note));
            chk($sformatf("%s%0d_en", tag, i), 8'(noteEnable), 8'(vq[i].en));
            chk($sformatf("%s%0d_idx", tag, i), 8'(stepIdx), 8'(vq[i].idx));
            chk($sformatf("%s%0d_play", tag, i), 8'(playing), 8'(vq[i].play));
            chk($sformatf("%s%0d_done", tag, i), 8'(donePulse), 8'(vq[i].done));
        end
        vq.delete();
    endtask

    task automatic drive(input logic st, sp, sw);
        start = st; stop = sp; switchNote = sw;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; switchNote = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, d, input logic sw);
        wif.wrEn = 1'b1; wif.wrAddr = a; wif.wrData = d; switchNote = sw;
        @(negedge clk);
        wif.wrEn = 1'b0; switchNote = 1'b0;
    endtask

    initial begin
        int i;
        wif.wrEn = 1'b0; wif.wrAddr = '0; wif.wrData = '0;

        // reset, then looping playback at full intensity
        add(1,0,0,0,1,1, 4'h0,0,4'd0,0,0);
        add(0,1,0,0,1,1, 4'h0,1,4'd0,1,0);
        for (int k = 1; k <= 18; k++) begin
            i = k % 16;
            add(0,0,0,1,1,1, mel[i], mel[i] != 4'hF, 4'(i),1,0);
        end
        add(0,1,0,0,1,1, 4'h0,1,4'd0,1,0);

        // intensity 3: only every 4th step sounds
        add(0,1,0,0,1,3, 4'h0,1,4'd0,1,0);
        for (int k = 1; k <= 16; k++) begin
            i = k % 16;
            add(0,0,0,1,1,3, mel[i], (i % 4 == 0) && mel[i] != 4'hF, 4'(i),1,0);
            if (k == 4) add(0,0,0,0,1,1, mel[4],1,4'd4,1,0);
        end
        add(0,1,0,0,1,0, 4'h0,0,4'd0,1,0);
        for (int k = 1; k <= 4; k++) add(0,0,0,1,1,0, mel[k],0,4'(k),1,0);
        add(0,0,1,0,1,0, mel[4],0,4'd4,0,0);
        add(0,0,0,1,1,1, mel[4],0,4'd4,0,0);

        // one-shot run to completion
        add(0,1,0,0,0,1, 4'h0,1,4'd0,1,0);
        for (int k = 1; k <= 15; k++) add(0,0,0,1,0,1, mel[k], mel[k] != 4'hF, 4'(k),1,0);
        add(0,0,0,1,0,1, mel[15],0,4'd15,0,1);
        add(0,0,0,0,0,1, mel[15],0,4'd15,0,0);
        add(0,0,0,1,0,1, mel[15],0,4'd15,0,0);
        run_vecs("a");

        // table writes during playback
        loopMode = 1'b1; intensity = 4'd1;
        drive(1,0,0);
        for (int k = 0; k < 3; k++) drive(0,0,1);
        chk("t4_idx3", 8'(stepIdx), 8'd3);
        wr(4'd5, 4'hF, 1'b0);
        drive(0,0,1);
        chk("t4_idx4_note", 8'(note), 8'h5);
        chk("t4_idx4_en", 8'(noteEnable), 8'd1);
        drive(0,0,1);
        chk("t4_rest_note", 8'(note), 8'hF);
        chk("t4_rest_en", 8'(noteEnable), 8'd0);
        wr(4'd6, 4'h3, 1'b1);
        chk("t4_wfirst_idx", 8'(stepIdx), 8'd6);
        chk("t4_wfirst_note", 8'(note), 8'h3);
        chk("t4_wfirst_en", 8'(noteEnable), 8'd1);
        wr(4'd6, 4'h8, 1'b0);
        chk("t4_cur_hold", 8'(note), 8'h3);
        wr(4'd5, 4'h7, 1'b0);
        wr(4'd6, 4'h9, 1'b0);

        // start+stop collision, reset mid-play, table intact afterwards
        add(1,0,0,0,1,1, 4'h0,0,4'd0,0,0);
        add(0,1,1,0,1,1, 4'h0,0,4'd0,0,0);
        add(0,1,0,0,1,1, 4'h0,1,4'd0,1,0);
        for (int k = 1; k <= 7; k++) add(0,0,0,1,1,1, mel[k], mel[k] != 4'hF, 4'(k),1,0);
        add(1,0,0,1,1,1, 4'h0,0,4'd0,0,0);
        add(0,1,0,0,1,1, 4'h0,1,4'd0,1,0);
        for (int k = 1; k <= 7; k++) add(0,0,0,1,1,1, mel[k], mel[k] != 4'hF, 4'(k),1,0);
        run_vecs("b");

`ifdef MUS_SEQ_TRANSPOSE_EN
        transpose = 4'd3;
        wr(4'd0, 4'hE, 1'b0);
        drive(1,0,0);
        chk("t6_sat_hi", 8'(note), 8'hE);
        chk("t6_sat_hi_en", 8'(noteEnable), 8'd1);
        transpose = 4'hE;
        wr(4'd0, 4'h0, 1'b0);
        drive(1,0,0);
        chk("t6_sat_lo", 8'(note), 8'h0);
        transpose = 4'd3;
        drive(0,0,1);
        chk("t6_latched", 8'(note), 8'hA);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
